// File: rtl/dmem_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | dmem_arbiter_pkg                                                           |
// | Shared types and defaults for the data-memory arbiter.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package dmem_arbiter_pkg;

    typedef enum logic [0:0] {
        NORMAL    = 1'b0,
        DBG_BOOST = 1'b1
    } arb_state_e;

    localparam int unsigned c_starve_limit_def = 4;
    localparam int unsigned c_depth_words_def  = 128;
    localparam int unsigned c_word_idx_w       = 30;

    // Word access only: the byte offset never affects the range decision.
    function automatic logic word_in_range(input logic [31:0] addr, input logic [31:0] depth);
        logic [c_word_idx_w-1:0] idx;
        idx = addr[31:2];
        return ({2'b00, idx} < depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_port_rsp.sv
// +----------------------------------------------------------------------------+
// | dmem_port_rsp                                                              |
// | One-cycle read response / error register for a single requester port.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_port_rsp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gnt,
    input  logic        we,
    input  logic        in_range,
    input  logic [31:0] mem_rdata,
    output logic        rvalid,
    output logic        err,
    output logic [31:0] rdata
);

    logic        rvalid_d, rvalid_q;
    logic        err_d, err_q;
    logic [31:0] rdata_d, rdata_q;

    always_comb begin
        rvalid_d = gnt & ~we;
        err_d    = gnt & ~in_range;
        rdata_d  = rdata_q;
        // Out-of-range reads still respond, but with zero data.
        if (gnt && !we) begin
            rdata_d = in_range ? mem_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +----------------------------------------------------------------------------+
// | dmem_arbiter                                                               |
// | CPU / debug arbiter for a single-port data memory with starvation boost.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = c_starve_limit_def,
    parameter int unsigned DEPTH_WORDS  = c_depth_words_def
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic        dbg_err,
    output logic [31:0] dbg_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0]  c_limit = 4'(STARVE_LIMIT);
    localparam logic [31:0] c_depth = 32'(DEPTH_WORDS);

    arb_state_e  state_d, state_q;
    logic [3:0]  starve_d, starve_q;
    logic        sel_we;
    logic        sel_in_range;
    logic        any_gnt;

    // Grants are gated by reset so nothing is granted while rst_n is low.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst_n) begin
            if (state_q == NORMAL) begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req & ~cpu_req;
            end else begin
                dbg_gnt = dbg_req;
                cpu_gnt = cpu_req & ~dbg_req;
            end
        end
    end

    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        sel_we    = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            sel_we    = cpu_we;
        end else if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            sel_we    = dbg_we;
        end
        any_gnt      = cpu_gnt | dbg_gnt;
        sel_in_range = word_in_range(mem_addr, c_depth);
        mem_write    = rst_n & any_gnt &  sel_we & sel_in_range;
        mem_read     = rst_n & any_gnt & ~sel_we & sel_in_range;
    end

    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (dbg_gnt) begin
            starve_d = 4'd0;
        end else if (dbg_req && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end

        case (state_q)
            NORMAL: begin
                // >= keeps the boost reachable if the counter was left above the limit.
                if (dbg_req && !dbg_gnt && (starve_d >= c_limit)) begin
                    state_d = DBG_BOOST;
                end
            end
            DBG_BOOST: begin
                if (dbg_gnt || !dbg_req) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NORMAL;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    dmem_port_rsp u_cpu_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (cpu_gnt),
        .we        (cpu_we),
        .in_range  (sel_in_range),
        .mem_rdata (mem_rdata),
        .rvalid    (cpu_rvalid),
        .err       (cpu_err),
        .rdata     (cpu_rdata)
    );

    dmem_port_rsp u_dbg_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (dbg_gnt),
        .we        (dbg_we),
        .in_range  (sel_in_range),
        .mem_rdata (mem_rdata),
        .rvalid    (dbg_rvalid),
        .err       (dbg_err),
        .rdata     (dbg_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter                                                            |
// | Directed self-checking bench for dmem_arbiter with a behavioural memory.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    logic [31:0] mem [0:127];
    int          checks;
    int          errors;

    dmem_arbiter #(.STARVE_LIMIT(4), .DEPTH_WORDS(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_err    (cpu_err),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_err    (dbg_err),
        .dbg_rdata  (dbg_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[8:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i);

        // Reset with a CPU write already requested: nothing may be granted or written.
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h5555_5555;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
        #12;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_outs", {26'd0, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_err, dbg_err, mem_read}, 32'd0);
        chk("rst_rdata", cpu_rdata | dbg_rdata, 32'd0);
        chk("rst_mem_untouched", mem[4], 32'hA000_0004);
        @(negedge clk);
        rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        @(posedge clk); #1;
        chk("rst_state", 32'(dut.state_q), 32'(NORMAL));
        chk("rst_starve", 32'(dut.starve_q), 32'd0);

        // CPU write 0x10 then read it back.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("wr_mem_write", 32'(mem_write), 32'd1);
        chk("wr_mem_addr", mem_addr, 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd_mem_read", {30'd0, mem_read, mem_write}, 32'd2);
        @(posedge clk); #1;
        chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("idle_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        chk("rd_rvalid_drop", 32'(cpu_rvalid), 32'd0);
        chk("rd_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

        // Both requesting continuously: debug wins every fifth cycle.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4;
        for (int k = 1; k <= 10; k++) begin
            #1;
            chk($sformatf("starve_cpu_gnt_c%0d", k), 32'(cpu_gnt), (k % 5 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("starve_dbg_gnt_c%0d", k), 32'(dbg_gnt), (k % 5 == 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            chk($sformatf("starve_dbg_rvalid_c%0d", k), 32'(dbg_rvalid), (k % 5 == 0) ? 32'd1 : 32'd0);
            if (k == 4) chk("starve_boost_state", 32'(dut.state_q), 32'(DBG_BOOST));
            if (k == 5) chk("starve_dbg_rdata", dbg_rdata, 32'hA000_0001);
            @(negedge clk);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        chk("starve_back_normal", 32'(dut.state_q), 32'(NORMAL));

        // Debug out-of-range write, then out-of-range read.
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'h1234_5678;
        #1;
        chk("oor_wr_gnt", {30'd0, dbg_gnt, cpu_gnt}, 32'd2);
        chk("oor_wr_mem_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        chk("oor_wr_err", {30'd0, dbg_err, dbg_rvalid}, 32'd2);
        @(negedge clk);
        dbg_we = 1'b0; dbg_addr = 32'h400;
        #1;
        chk("oor_rd_mem_read", 32'(mem_read), 32'd0);
        @(posedge clk); #1;
        chk("oor_rd_flags", {30'd0, dbg_err, dbg_rvalid}, 32'd3);
        chk("oor_rd_rdata", dbg_rdata, 32'd0);
        @(negedge clk);
        dbg_req = 1'b0;
        @(posedge clk); #1;
        chk("oor_err_drop", 32'(dbg_err), 32'd0);
        chk("oor_mem_unchanged", mem[0], 32'hA000_0000);

        // Starve debug twice, then reset lands on debug's grant edge.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h7FC;
        @(posedge clk); @(negedge clk);
        @(posedge clk); #1;
        chk("rst_mid_starve2", 32'(dut.starve_q), 32'd2);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("rst_mid_dbg_gnt", 32'(dbg_gnt), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_forced", {29'd0, dbg_gnt, mem_read, mem_write}, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_rsp", {30'd0, dbg_rvalid, dbg_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; dbg_req = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_rvalid_after", 32'(dbg_rvalid), 32'd0);
        chk("rst_mid_starve", 32'(dut.starve_q), 32'd0);
        chk("rst_mid_state", 32'(dut.state_q), 32'(NORMAL));

        // Debug alone: three back-to-back reads.
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dbg_addr = 32'(k * 4);
            #1;
            chk($sformatf("b2b_gnt_%0d", k), {30'd0, dbg_gnt, cpu_gnt}, 32'd2);
            @(posedge clk); #1;
            chk($sformatf("b2b_rvalid_%0d", k), 32'(dbg_rvalid), 32'd1);
            chk($sformatf("b2b_rdata_%0d", k), dbg_rdata, 32'hA000_0000 + 32'(k));
            @(negedge clk);
        end
        dbg_req = 1'b0;
        @(posedge clk); #1;
        chk("b2b_rvalid_end", 32'(dbg_rvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
